// File: rtl/accumulator_pkg.sv
// accumulator_pkg: shared widths, differentiator FSM states and recovered-sample range limits
package accumulator_pkg;
   localparam int P_W_DFLT = 38;
   localparam int A_W_DFLT = 20;
   localparam longint A_MAX = (longint'(1) <<< (A_W_DFLT - 1)) - 1;
   localparam longint A_MIN = -(longint'(1) <<< (A_W_DFLT - 1));
   typedef enum logic [1:0] {ZERO, RUN, ERR} diff_state_t;
endpackage

// File: rtl/acc_diff_range_chk.sv
// acc_diff_range_chk: fits a wide difference into A_W signed bits and flags out-of-range values
// ACC_DIFF_SAT_EN defined: out-of-range values saturate; otherwise the low A_W bits wrap
module acc_diff_range_chk #(
   parameter int D_W = 39,
   parameter int A_W = 20
) (
   input  logic [D_W-1:0] d,
   output logic [A_W-1:0] a,
   output logic           ovf
);
   logic [D_W-A_W:0] top;
   // in range exactly when every bit from the sign down to bit A_W-1 agrees
   assign top = d[D_W-1:A_W-1];
   assign ovf = ~(&top | ~|top);
`ifdef ACC_DIFF_SAT_EN
   assign a = ovf ? {d[D_W-1], {(A_W-1){~d[D_W-1]}}} : d[A_W-1:0];
`else
   assign a = d[A_W-1:0];
`endif
endmodule

// File: rtl/accumulator_differentiator.sv
// accumulator_differentiator: recovers accumulator input samples as first differences of P
// (latency 2); saturation of out-of-range results is enabled by ACC_DIFF_SAT_EN
module accumulator_differentiator
   import accumulator_pkg::*;
#(
   parameter int P_W = P_W_DFLT,
   parameter int A_W = A_W_DFLT
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           valid_i,
   input  logic [P_W-1:0] P,
   input  logic           subtract_i,
   input  logic           clear_i,
   output logic [A_W-1:0] A,
   output logic           valid_o,
   output logic           ovf_o
);
   logic signed [P_W-1:0] prev;
   logic signed [P_W:0]   pe, qe, d, d1;
   logic                  v1, take, rng_ovf;
   logic [A_W-1:0]        rng_a;
   diff_state_t           state, state_nx;

   assign take = valid_i & ~clear_i;
   assign pe = (P_W+1)'($signed(P));
   assign qe = (P_W+1)'(prev);
   // one extra bit keeps the difference from wrapping
   assign d = subtract_i ? qe - pe : pe - qe;
   assign ovf_o = (state == ERR);

   acc_diff_range_chk #(.D_W(P_W + 1), .A_W(A_W)) u_rng (
      .d   (d1),
      .a   (rng_a),
      .ovf (rng_ovf)
   );

   // next state: clear dominates, then a stage-2 overflow, then the first accepted sample
   always_comb begin
      state_nx = clear_i ? ZERO : (v1 & rng_ovf) ? ERR : (state == ZERO && take) ? RUN : state;
   end

   // previous-sample register, both pipeline stages and the FSM state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev    <= '0;
         d1      <= '0;
         v1      <= 1'b0;
         A       <= '0;
         valid_o <= 1'b0;
         state   <= ZERO;
      end else begin
         prev    <= clear_i ? '0 : take ? $signed(P) : prev;
         d1      <= take ? d : d1;
         v1      <= take;
         A       <= v1 ? rng_a : A;
         valid_o <= v1;
         state   <= state_nx;
      end
   end
endmodule

// File: tb/tb_accumulator_differentiator.sv
// tb_accumulator_differentiator: directed and loopback checks against a behavioural difference model
module tb_accumulator_differentiator;
   import accumulator_pkg::*;

   localparam int PW = 38;
   localparam int AW = 20;
   localparam int N = 4096;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          valid_i = 1'b0;
   logic [PW-1:0] P = '0;
   logic          subtract_i = 1'b0;
   logic          clear_i = 1'b0;
   logic [AW-1:0] A;
   logic          valid_o;
   logic          ovf_o;

   int checks = 0;
   int errors = 0;
   int e = 0;
   longint prev_m = 0;
   logic   m_ovf = 1'b0;
   logic [AW-1:0] last_a = '0;
   logic          exp_v [N];
   logic          exp_o [N];
   logic [AW-1:0] exp_a [N];

   accumulator_differentiator dut (
      .clk        (clk),
      .reset      (reset),
      .valid_i    (valid_i),
      .P          (P),
      .subtract_i (subtract_i),
      .clear_i    (clear_i),
      .A          (A),
      .valid_o    (valid_o),
      .ovf_o      (ovf_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, got, want);
      end
   endtask

   // drive one cycle at the negedge, predict, cross the edge, then check at the next negedge
   task automatic step(input bit v, input longint p, input bit s, input bit c);
      longint dd;
      logic [AW-1:0] ea;
      valid_i = v;
      P = p[PW-1:0];
      subtract_i = s;
      clear_i = c;
      exp_v[e+1] = 1'b0;
      if (v && !c) begin
         dd = s ? prev_m - p : p - prev_m;
         ea = dd[AW-1:0];
`ifdef ACC_DIFF_SAT_EN
         if (dd > A_MAX) ea = A_MAX[AW-1:0];
         if (dd < A_MIN) ea = A_MIN[AW-1:0];
`endif
         exp_v[e+1] = 1'b1;
         exp_a[e+1] = ea;
         exp_o[e+1] = (dd > A_MAX) || (dd < A_MIN);
         prev_m = p;
      end
      if (c) prev_m = 0;
      @(posedge clk);
      @(negedge clk);
      if (c) m_ovf = 1'b0;
      else if (exp_v[e] && exp_o[e]) m_ovf = 1'b1;
      if (exp_v[e]) last_a = exp_a[e];
      chk($sformatf("valid_o@%0d", e), 64'(valid_o), 64'(exp_v[e]));
      chk($sformatf("A@%0d", e), 64'(A), 64'(last_a));
      chk($sformatf("ovf_o@%0d", e), 64'(ovf_o), 64'(m_ovf));
      e++;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         exp_v[i] = 1'b0;
         exp_o[i] = 1'b0;
         exp_a[i] = '0;
      end
      repeat (2) @(negedge clk);
      chk("reset_A", 64'(A), 64'(0));
      chk("reset_valid_o", 64'(valid_o), 64'(0));
      chk("reset_ovf_o", 64'(ovf_o), 64'(0));
      reset = 1'b1;
      // 1. reset mid-stream flushes in-flight samples
      step(1, 11, 0, 0);
      step(1, 40, 0, 0);
      valid_i = 1'b1;
      P = 38'd77;
      #2 reset = 1'b0;
      #1;
      chk("midrst_A", 64'(A), 64'(0));
      chk("midrst_valid_o", 64'(valid_o), 64'(0));
      chk("midrst_ovf_o", 64'(ovf_o), 64'(0));
      prev_m = 0;
      m_ovf = 1'b0;
      last_a = '0;
      for (int i = e; i < e + 4; i++) exp_v[i] = 1'b0;
      @(posedge clk);
      e++;
      @(negedge clk);
      reset = 1'b1;
      for (int i = e; i < e + 4; i++) exp_v[i] = 1'b0;
      step(1, 5, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("post_reset_A5", 64'(A), 64'(5));
      // 2. add mode
      step(1, 38'hFFFFF, 0, 0);
      step(1, 38'h1FFFFE, 0, 0);
      step(1, 38'h1FFFFD, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("add_last_A", 64'(A), 64'(20'hFFFFF));
      step(0, 0, 0, 1);
      // 3. subtract mode
      step(1, -7, 1, 0);
      step(1, -7, 1, 0);
      step(1, 3, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      chk("sub_last_A", 64'(A), 64'(20'hFFFF6));
      // 4. overflow from prev=0
      step(0, 0, 0, 1);
      step(1, 64'sd524288, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("ovf_set", 64'(ovf_o), 64'(1));
`ifdef ACC_DIFF_SAT_EN
      chk("ovf_A", 64'(A), 64'(20'h7FFFF));
`else
      chk("ovf_A", 64'(A), 64'(20'h80000));
`endif
      step(1, 12, 0, 0);
      step(0, 0, 0, 1);
      chk("ovf_cleared", 64'(ovf_o), 64'(0));
      // 5. clear colliding with valid, with a sample already in flight
      step(1, 9, 0, 0);
      step(1, 100, 0, 1);
      step(1, 30, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("collision_A30", 64'(A), 64'(30));
      // 6. loopback through an ideal accumulator
      step(0, 0, 0, 1);
      begin
         longint acc = 0;
         longint a;
         int n = 0;
         while (n < 1032) begin
            bit v = ($urandom_range(0, 3) != 0);
            bit s = (n >= 32);
            if (v) begin
               a = longint'($urandom_range(0, (1 << AW) - 1)) - (longint'(1) <<< (AW - 1));
               acc = s ? acc - a : acc + a;
               step(1, acc, s, 0);
               n++;
            end else begin
               step(0, longint'($urandom), s, 0);
            end
         end
      end
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("loopback_ovf", 64'(ovf_o), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
